// File: rtl/exmem_pkg.sv
// exmem_pkg: shared state encoding, base address and defaults for the user-area external memory
package exmem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
    localparam logic [31:0] EXMEM_BASE = 32'h38400000;
    localparam int DEF_DELAYS = 10;
    localparam int DEF_MEM_WORDS = 1024;
endpackage

// File: rtl/wb_exmem_ram.sv
// wb_exmem_ram: single-port synchronous RAM with byte write enables and a registered read port
module wb_exmem_ram #(
    parameter int BITS = 32,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            en,
    input  logic [3:0]      we,
    input  logic [AW-1:0]   addr,
    input  logic [BITS-1:0] wdata,
    output logic [BITS-1:0] rdata
);
    logic [BITS-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/wb_exmem.sv
// wb_exmem: Wishbone slave emulating slow external memory with fixed access latency
module wb_exmem import exmem_pkg::*; #(
    parameter int BITS = 32,
    parameter int DELAYS = DEF_DELAYS,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic            wbs_clk_i,
    input  logic            wbs_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [BITS-1:0] wbs_adr_i,
    input  logic [BITS-1:0] wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [BITS-1:0] wbs_dat_o
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    state_t state;
    logic [CW-1:0] cnt;
    logic req, fire, a_we, lat_we, rd;
    logic [3:0] a_sel, lat_sel;
    logic [AW-1:0] a_idx, lat_idx;
    logic [BITS-1:0] a_dat, lat_dat, q;
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[BITS-1:AW+2], wbs_adr_i[1:0]};
    assign req = wbs_cyc_i & wbs_stb_i;
    // With zero delay the access fires on the sampling edge, so use the live bus values
    always_comb begin
        a_we  = (state == IDLE) ? wbs_we_i : lat_we;
        a_sel = (state == IDLE) ? wbs_sel_i : lat_sel;
        a_idx = (state == IDLE) ? wbs_adr_i[AW+1:2] : lat_idx;
        a_dat = (state == IDLE) ? wbs_dat_i : lat_dat;
        fire  = !wbs_rst_i && req && ((state == IDLE) ? (DELAYS == 0) : (state == WAIT && cnt == '0));
    end
    wb_exmem_ram #(.BITS(BITS), .AW(AW)) u_ram (
        .clk(wbs_clk_i),
        .en(fire),
        .we({4{fire & a_we}} & a_sel),
        .addr(a_idx),
        .wdata(a_dat),
        .rdata(q)
    );
    assign wbs_dat_o = rd ? q : '0;
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            state <= IDLE;
            cnt <= '0;
            wbs_ack_o <= 1'b0;
            rd <= 1'b0;
        end else begin
            wbs_ack_o <= fire;
            rd <= fire & ~a_we;
            case (state)
                IDLE: if (req) begin
                    lat_we <= wbs_we_i;
                    lat_sel <= wbs_sel_i;
                    lat_idx <= wbs_adr_i[AW+1:2];
                    lat_dat <= wbs_dat_i;
                    cnt <= CW'(DELAYS - 1);
                    state <= (DELAYS == 0) ? ACK : WAIT;
                end
                WAIT: begin
                    state <= !req ? IDLE : (cnt == '0) ? ACK : WAIT;
                    if (req && cnt != '0) cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_exmem.sv
// tb_wb_exmem: directed scoreboard bench for a DELAYS=10 and a DELAYS=0 instance sharing one bus
module tb_wb_exmem;
    logic clk = 0, rst = 1;
    logic cyc10 = 0, cyc0 = 0, stb = 0, we = 0;
    logic [3:0] sel = 0;
    logic [31:0] adr = 0, wdat = 0;
    logic ack10, ack0;
    logic [31:0] dat10, dat0;
    int total = 0, bad = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    wb_exmem dut (
        .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_cyc_i(cyc10), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack10), .wbs_dat_o(dat10)
    );
    wb_exmem #(.DELAYS(0)) dut0 (
        .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack0), .wbs_dat_o(dat0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit fast, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc10 = !fast; cyc0 = fast; stb = 1; we = w; adr = a; wdat = d; sel = s;
    endtask

    task automatic idle_bus();
        cyc10 = 0; cyc0 = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0;
    endtask

    // One access: ack must land exactly lat cycles after the request cycle, dat 0 until then
    task automatic access(input string tag, input bit fast, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_rd);
        int k;
        bit got, zero_ok;
        logic [31:0] e;
        sb.push_back(w ? 32'h0 : exp_rd);
        @(posedge clk); #1;
        drive(fast, w, a, d, s);
        k = 0; got = 0; zero_ok = 1;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (fast ? ack0 : ack10) got = 1;
            else if ((fast ? dat0 : dat10) !== 32'h0) zero_ok = 0;
            if (k == 2) begin we = !w; adr = 32'h0; wdat = 32'h0; sel = 4'h0; end
        end
        e = sb.pop_front();
        check({tag, "_lat"}, k, fast ? 1 : 11);
        check({tag, "_data"}, got ? (fast ? dat0 : dat10) : 32'hxxxxxxxx, e);
        check({tag, "_dat_idle"}, {31'b0, zero_ok}, 32'h1);
        idle_bus();
        @(posedge clk); #1;
        check({tag, "_ack_drop"}, {31'b0, fast ? ack0 : ack10}, 32'h0);
        check({tag, "_dat_drop"}, fast ? dat0 : dat10, 32'h0);
    endtask

    initial begin
        int k, n;
        bit stray;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack10", {31'b0, ack10}, 0);
        check("rst_dat10", dat10, 0);
        check("rst_ack0", {31'b0, ack0}, 0);
        rst = 0;

        access("wr_beef", 0, 1, 32'h38400010, 32'hDEADBEEF, 4'hF, 0);
        access("rd_beef", 0, 0, 32'h38400010, 0, 4'hF, 32'hDEADBEEF);
        access("rd_alias", 0, 0, 32'h00400010, 0, 4'hF, 32'hDEADBEEF);

        access("wr_full", 0, 1, 32'h38400020, 32'h11223344, 4'hF, 0);
        access("wr_mask", 0, 1, 32'h38400020, 32'hAABBCCDD, 4'b0101, 0);
        access("rd_mask", 0, 0, 32'h38400020, 0, 4'hF, 32'h11BB33DD);
        access("wr_sel0", 0, 1, 32'h38400020, 32'hFFFFFFFF, 4'h0, 0);
        access("rd_sel0", 0, 0, 32'h38400020, 0, 4'hF, 32'h11BB33DD);

        // Abort: drop stb five cycles into WAIT
        access("wr_zero", 0, 1, 32'h38400030, 32'h0, 4'hF, 0);
        @(posedge clk); #1;
        drive(0, 1, 32'h38400030, 32'hFFFFFFFF, 4'hF);
        repeat (6) @(posedge clk);
        #1;
        idle_bus();
        stray = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ack10 !== 1'b0 || dat10 !== 32'h0) stray = 1;
        end
        check("abort_no_ack", {31'b0, stray}, 0);
        access("rd_abort", 0, 0, 32'h38400030, 0, 4'hF, 32'h0);

        // Back-to-back reads with the request held high through ACK
        access("wr_w0", 0, 1, 32'h38400000, 32'h0BADF00D, 4'hF, 0);
        access("wr_w1", 0, 1, 32'h38400004, 32'h600DCAFE, 4'hF, 0);
        sb.push_back(32'h0BADF00D);
        sb.push_back(32'h600DCAFE);
        @(posedge clk); #1;
        drive(0, 0, 32'h38400000, 0, 4'hF);
        k = 0; n = 0;
        while (n < 2 && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (ack10) begin
                n++;
                check(n == 1 ? "b2b_lat1" : "b2b_lat2", k, n == 1 ? 11 : 23);
                check(n == 1 ? "b2b_data1" : "b2b_data2", dat10, sb.pop_front());
                adr = 32'h38400004;
            end
        end
        check("b2b_count", n, 2);
        idle_bus();
        sb.delete();

        // Reset mid-WAIT of a write
        access("wr_keep", 0, 1, 32'h38400040, 32'hCAFEF00D, 4'hF, 0);
        @(posedge clk); #1;
        drive(0, 1, 32'h38400040, 32'h12345678, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        idle_bus();
        @(posedge clk); #1;
        check("rstw_ack", {31'b0, ack10}, 0);
        check("rstw_dat", dat10, 0);
        rst = 0;
        access("rd_keep", 0, 0, 32'h38400040, 0, 4'hF, 32'hCAFEF00D);

        // Zero-latency instance
        access("f_wr", 1, 1, 32'h38400008, 32'hA5A55A5A, 4'hF, 0);
        access("f_rd", 1, 0, 32'h38400008, 0, 4'hF, 32'hA5A55A5A);
        access("f_wrm", 1, 1, 32'h38400008, 32'h00FF0000, 4'b0100, 0);
        access("f_rdm", 1, 0, 32'h38400008, 0, 4'hF, 32'hA5FF5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_exmem.md
# wb_exmem

Wishbone slave model of the user-area external memory, mapped at 32'h38400000 and driven by the exmem port of the user-area Wishbone address decoder. Serves single-word reads and byte-masked writes with a fixed, parameterised access latency, emulating slow off-chip memory for firmware and FIR data buffers. The block sits directly downstream of the decoder. Its ack/data outputs feed the decoder's return mux.

## Interface
- BITS, 32: data and address width; must be 32.
- DELAYS, 10: wait cycles inserted before ack; 0 is legal.
- MEM_WORDS, 1024: memory depth in 32-bit words, a power of two; AW = clog2(MEM_WORDS).

Ports:
- wbs_clk_i  in  1  single clock for all logic.
- wbs_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe; request = cyc & stb.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte lane enables; bit n covers dat[8n+7:8n].
- wbs_adr_i  in  BITS  byte address; word index = adr[AW+1:2], other bits ignored.
- wbs_dat_i  in  BITS  write data.
- wbs_ack_o  out  1  one-cycle transfer acknowledge.
- wbs_dat_o  out  BITS  read data; valid only while ack is high.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE, no request: stay in IDLE.
- IDLE, request sampled at edge E0:
  - latch we, sel, word index and write data;
  - if DELAYS==0, go to ACK;
  - otherwise go to WAIT with cnt = DELAYS-1.
- WAIT, request still high at an edge:
  - cnt==0: go to ACK;
  - otherwise cnt decrements.
- WAIT, cyc or stb low at any edge: abort. Go to IDLE with no write and no ack.
- On the edge entering ACK, the access is performed:
  - Write: update only the bytes whose sel bit is set, using latched data. sel=0 is a legal write that changes nothing.
  - Read: wbs_dat_o <= mem[index].
  - Write ack: wbs_dat_o <= 0.
- ACK lasts one cycle, then IDLE. wbs_dat_o returns to 0 when ack drops.
- A request held high through ACK is a new request, sampled in IDLE on the next edge. Back-to-back accesses are therefore separated by one IDLE cycle.
- Changes to adr, we, sel or dat_i after E0 are ignored for the current access.
- Reset (any state, including mid-WAIT):
  - state = IDLE, cnt = 0;
  - wbs_ack_o = 0, wbs_dat_o = 0;
  - a pending write is dropped;
  - memory contents are not cleared.
- Out-of-window high address bits alias; range checking is the decoder's job.

## Timing
- Request first high in cycle c (sampled at E0). wbs_ack_o is high in cycle c+DELAYS+1, for exactly one cycle.
- Outputs are fully registered; there is no combinational path from inputs to ack or dat.
- Read data is coherent with any write acked earlier, including the immediately preceding access.
- Throughput: one access per DELAYS+2 cycles.

## Structure
- Package exmem_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2);
  - EXMEM_BASE = 32'h38400000;
  - default DELAYS and MEM_WORDS.
- The decoder references EXMEM_BASE from the same package.
- Sub-module wb_exmem_ram: single-port synchronous RAM with a 4-bit byte write enable and a registered read port.
  - The read port is enabled on the edge entering ACK, so ack and data align.
  - Top level holds the FSM, counter, request latches and output registers.

## Test plan
- Write 32'hDEADBEEF to 32'h38400010 with sel=4'hF, then read it back:
  - each ack arrives exactly 11 cycles after stb rises (DELAYS=10);
  - read returns 32'hDEADBEEF;
  - wbs_dat_o is 0 outside the ack cycle.
- Byte mask:
  - write 32'h11223344 to 32'h38400020 with sel=4'hF;
  - write 32'hAABBCCDD with sel=4'b0101;
  - read returns 32'h11BB33DD.
- Abort: drop stb in cycle 5 of WAIT during a write of 32'hFFFFFFFF to a word holding 32'h0.
  - No ack is issued.
  - A later read returns 32'h0.
  - The next request is served with full latency.
- Back-to-back: stb held high across two reads of 32'h38400000 and 32'h38400004.
  - Acks occur at cycles c+11 and c+23.
  - Each carries the correct data.
- Reset mid-WAIT during a write:
  - ack and dat are 0 on the next cycle;
  - no write occurs;
  - earlier memory contents survive.
- DELAYS=0 build: ack in cycle c+1; read-after-write returns the written data.
